// File: rtl/vx_fpu_csr_file_pkg.sv
// Shared FP CSR types: field layouts, CSR addresses and CSR-instruction op encodings.
// Imported by the per-warp FP CSR file that sits next to the FPU.
package fpu_types;

  localparam int FFLAGS_W = 5;
  localparam int FRM_W    = 3;

  typedef logic [FFLAGS_W-1:0] fflags_t;  // {NV,DZ,OF,UF,NX}
  typedef logic [FRM_W-1:0]    frm_t;

  // Packed so the 8-bit storage word is bit-identical to fcsr[7:0].
  typedef struct packed {
    frm_t    frm;
    fflags_t fflags;
  } fp_csr_t;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    CSR_OP_RO = 2'd0,
    CSR_OP_RW = 2'd1,
    CSR_OP_RS = 2'd2,
    CSR_OP_RC = 2'd3
  } csr_op_e;

endpackage

// File: rtl/vx_fpu_csr_file.sv
// Per-warp fflags/frm storage: accumulates FPU flags, serves dynamic rounding mode,
// and executes CSR read-modify-writes with a one-entry registered response slot.
module vx_fpu_csr_file
  import fpu_types::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fflags_we,
  input  logic [NW_BITS-1:0]   fflags_wid,
  input  logic [4:0]           fflags_in,
  input  logic [NW_BITS-1:0]   read_wid,
  output logic [2:0]           read_frm,
  input  logic [NUM_WARPS-1:0] fpu_pending,
  input  logic                 csr_req_valid,
  output logic                 csr_req_ready,
  input  logic [NW_BITS-1:0]   csr_req_wid,
  input  logic [11:0]          csr_req_addr,
  input  logic [1:0]           csr_req_op,
  input  logic [31:0]          csr_req_data,
  output logic                 csr_rsp_valid,
  input  logic                 csr_rsp_ready,
  output logic [31:0]          csr_rsp_data,
  output logic [NUM_WARPS-1:0] csr_pending
);

  fp_csr_t              csr_q [NUM_WARPS];
  fp_csr_t              csr_d [NUM_WARPS];
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic [NW_BITS-1:0]   rsp_wid_q, rsp_wid_d;
  logic [NUM_WARPS-1:0] pending_q, pending_d;

  logic        accept;
  logic        addr_hit;
  logic        wr_en;
  fp_csr_t     old_csr;
  fp_csr_t     new_csr;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        unused_new_val;

  // Ready never looks at valid, so the requester can't form a combinational loop.
  assign csr_req_ready = (!rsp_valid_q || csr_rsp_ready) && !fpu_pending[csr_req_wid];
  assign accept        = csr_req_valid && csr_req_ready;

  // NOTE: every variable written in always_comb gets a default first; otherwise a path
  // that skips an assignment infers a latch.
  always_comb begin
    old_csr  = csr_q[csr_req_wid];
    addr_hit = 1'b1;
    old_val  = 32'd0;
    case (csr_req_addr)
      CSR_FFLAGS: old_val = {27'd0, old_csr.fflags};
      CSR_FRM:    old_val = {29'd0, old_csr.frm};
      CSR_FCSR:   old_val = {24'd0, old_csr};
      default:    addr_hit = 1'b0;
    endcase

    new_val = old_val;
    case (csr_op_e'(csr_req_op))
      CSR_OP_RW: new_val = csr_req_data;
      CSR_OP_RS: new_val = old_val | csr_req_data;
      CSR_OP_RC: new_val = old_val & ~csr_req_data;
      default:   new_val = old_val;
    endcase
    wr_en = accept && addr_hit && (csr_op_e'(csr_req_op) != CSR_OP_RO);

    // Operand is truncated to the addressed field's width.
    new_csr = old_csr;
    case (csr_req_addr)
      CSR_FFLAGS: new_csr.fflags = new_val[4:0];
      CSR_FRM:    new_csr.frm    = new_val[2:0];
      CSR_FCSR:   new_csr        = new_val[7:0];
      default:    new_csr        = old_csr;
    endcase
  end

  assign unused_new_val = ^new_val[31:8];

  // FPU flags are OR-ed in after the CSR write so a coincident commit is never lost.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      csr_d[w] = csr_q[w];
      if (wr_en && (csr_req_wid == NW_BITS'(w))) begin
        csr_d[w] = new_csr;
      end
      if (fflags_we && (fflags_wid == NW_BITS'(w))) begin
        csr_d[w].fflags = csr_d[w].fflags | fflags_in;
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_wid_d   = rsp_wid_q;
    pending_d   = pending_q;
    if (rsp_valid_q && csr_rsp_ready) begin
      rsp_valid_d          = 1'b0;
      pending_d[rsp_wid_q] = 1'b0;
    end
    // A new accept for the same warp overrides the clear above.
    if (accept) begin
      rsp_valid_d            = 1'b1;
      rsp_data_d             = addr_hit ? old_val : 32'd0;
      rsp_wid_d              = csr_req_wid;
      pending_d[csr_req_wid] = 1'b1;
    end
  end

  // NOTE: the per-warp array is reset like any other flop because software may read
  // fflags/frm before ever writing them and must see zeros (RNE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        csr_q[w] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_wid_q   <= '0;
      pending_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      for (int w = 0; w < NUM_WARPS; w++) begin
        csr_q[w] <= csr_d[w];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_wid_q   <= rsp_wid_d;
      pending_q   <= pending_d;
    end
  end

  assign read_frm      = csr_q[read_wid].frm;
  assign csr_rsp_valid = rsp_valid_q;
  assign csr_rsp_data  = rsp_data_q;
  assign csr_pending   = pending_q;

endmodule
